// File: rtl/dqn_pkg.sv
// Shared fixed-point constants, parameter index map, FSM states and saturation helper
// for the DQN weight-update block.
package dqn_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 8;
   localparam int WIDE_W    = 40;

   localparam int W3_BASE = 0;
   localparam int B3_BASE = 20;
   localparam int W2_BASE = 24;
   localparam int B2_BASE = 69;
   localparam int N_PARAM = 74;

   typedef enum logic {
      ACCUM = 1'b0,
      APPLY = 1'b1
   } state_t;

   // Clamp a wide signed intermediate into the 16-bit weight range.
   function automatic logic signed [DATA_W-1:0] sat16(input logic signed [WIDE_W-1:0] v);
      if (v > 40'sd32767)
         return 16'sh7FFF;
      else if (v < -40'sd32768)
         return 16'sh8000;
      else
         return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/dqn_weight_update_if.sv
// Gradient stream, init write, read port and status of the weight-update block.
// No handshake: upstream holds off while busy; reads have one-cycle latency.
interface dqn_weight_update_if #(
   parameter int LOG2_BATCH = 2
);
   logic                grad_valid;
   logic [6:0]          grad_idx;
   logic [15:0]         grad_data;
   logic                sample_done;
   logic [15:0]         lr;
   logic                init_valid;
   logic [6:0]          init_idx;
   logic [15:0]         init_data;
   logic [6:0]          rd_idx;
   logic [15:0]         rd_data;
   logic                busy;
   logic                update_done;
   logic [LOG2_BATCH:0] sample_cnt;

   modport master (
      output grad_valid, grad_idx, grad_data, sample_done, lr,
             init_valid, init_idx, init_data, rd_idx,
      input  rd_data, busy, update_done, sample_cnt
   );

   modport slave (
      input  grad_valid, grad_idx, grad_data, sample_done, lr,
             init_valid, init_idx, init_data, rd_idx,
      output rd_data, busy, update_done, sample_cnt
   );
endinterface

// File: rtl/dqn_sgd_step.sv
// Combinational SGD step: w_new = sat16(w - floor(lr*acc / 2^(FRAC_BITS+LOG2_BATCH))).
// Zero latency, no backpressure; the shift folds the batch mean into the scaling.
module dqn_sgd_step #(
   parameter int ACC_W      = 19,
   parameter int FRAC_BITS  = 8,
   parameter int LOG2_BATCH = 2
) (
   input  logic signed [15:0]      w,
   input  logic signed [ACC_W-1:0] acc,
   input  logic        [15:0]      lr,
   output logic signed [15:0]      w_new
);
   import dqn_pkg::*;

   localparam int PROD_W = ACC_W + 17;
   localparam int SHIFT  = FRAC_BITS + LOG2_BATCH;

   logic signed [PROD_W-1:0] lr_ext;
   logic signed [PROD_W-1:0] acc_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] step;
   logic signed [WIDE_W-1:0] w_ext;
   logic signed [WIDE_W-1:0] step_ext;
   logic signed [WIDE_W-1:0] diff;

   // lr is unsigned, so it enters the signed product zero-extended.
   assign lr_ext   = {{(PROD_W-16){1'b0}}, lr};
   assign acc_ext  = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
   assign prod     = lr_ext * acc_ext;
   assign step     = prod >>> SHIFT;
   assign w_ext    = {{(WIDE_W-16){w[15]}}, w};
   assign step_ext = {{(WIDE_W-PROD_W){step[PROD_W-1]}}, step};
   assign diff     = w_ext - step_ext;
   assign w_new    = sat16(diff);

endmodule

// File: rtl/dqn_weight_update.sv
// Accumulates per-sample gradients over BATCH samples, then sweeps one parameter per cycle
// (74 cycles busy). Read port has one-cycle latency; inputs other than reads are dropped while busy.
module dqn_weight_update #(
   parameter int BATCH      = 4,
   parameter int LOG2_BATCH = 2,
   parameter int FRAC_BITS  = dqn_pkg::FRAC_BITS,
   parameter int N_PARAM    = dqn_pkg::N_PARAM
) (
   input  logic             clk,
   input  logic             rst,
   dqn_weight_update_if.slave bus
);
   import dqn_pkg::*;

   localparam int ACC_W = 16 + LOG2_BATCH + 1;
   localparam int CNT_W = LOG2_BATCH + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);
   localparam logic [6:0]       IDX_LIM  = 7'(N_PARAM);
   localparam logic [6:0]       PTR_LAST = 7'(N_PARAM - 1);

   state_t                   state;
   logic [6:0]               ptr;
   logic [15:0]              lr_q;
   logic [CNT_W-1:0]         cnt;
   logic                     busy_q;
   logic                     done_q;
   logic [15:0]              rd_q;
   logic signed [15:0]       w_mem   [N_PARAM];
   logic signed [ACC_W-1:0]  acc_mem [N_PARAM];

   logic                     grad_ok;
   logic                     init_ok;
   logic                     rd_ok;
   logic [6:0]               grad_sel;
   logic signed [ACC_W-1:0]  acc_cur;
   logic [ACC_W:0]           acc_sum;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [15:0]       w_new;

   assign grad_ok  = bus.grad_idx < IDX_LIM;
   assign init_ok  = bus.init_idx < IDX_LIM;
   assign rd_ok    = bus.rd_idx   < IDX_LIM;
   assign grad_sel = grad_ok ? bus.grad_idx : 7'd0;
   assign acc_cur  = acc_mem[grad_sel];

   // Saturating accumulate: one guard bit detects overflow of the ACC_W-bit sum.
   always_comb begin
      acc_sum  = {acc_cur[ACC_W-1], acc_cur}
               + {{(ACC_W+1-16){bus.grad_data[15]}}, bus.grad_data};
      acc_next = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
         acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
   end

   dqn_sgd_step #(
      .ACC_W      (ACC_W),
      .FRAC_BITS  (FRAC_BITS),
      .LOG2_BATCH (LOG2_BATCH)
   ) u_step (
      .w     (w_mem[ptr]),
      .acc   (acc_mem[ptr]),
      .lr    (lr_q),
      .w_new (w_new)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ACCUM;
         ptr    <= 7'd0;
         lr_q   <= 16'd0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         rd_q   <= 16'd0;
         for (int i = 0; i < N_PARAM; i++) begin
            w_mem[i]   <= '0;
            acc_mem[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         // Read-before-write: this samples the array before any write of this cycle lands.
         rd_q   <= rd_ok ? w_mem[bus.rd_idx] : 16'd0;
         case (state)
            ACCUM: begin
               if (bus.grad_valid && grad_ok)
                  acc_mem[bus.grad_idx] <= acc_next;
               if (bus.init_valid && init_ok)
                  w_mem[bus.init_idx] <= bus.init_data;
               if (bus.sample_done) begin
                  if (cnt == CNT_LAST) begin
                     state  <= APPLY;
                     busy_q <= 1'b1;
                     ptr    <= 7'd0;
                     lr_q   <= bus.lr;
                     cnt    <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            APPLY: begin
               w_mem[ptr]   <= w_new;
               acc_mem[ptr] <= '0;
               if (ptr == PTR_LAST) begin
                  state  <= ACCUM;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  ptr <= ptr + 7'd1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign bus.rd_data     = rd_q;
   assign bus.busy        = busy_q;
   assign bus.update_done = done_q;
   assign bus.sample_cnt  = cnt;

endmodule

// File: doc/dqn_weight_update.md
Name: dqn_weight_update

Overview:
- Downstream neighbour of the backward stage.
- Consumes the per-sample gradient words (deltaw3, deltab3, deltaw2, deltab2) as a serial indexed stream and accumulates them over a mini-batch of BATCH samples.
- After the last sample of a batch, sweeps all 74 parameters one per cycle, applying w <- w - lr*mean(grad) with saturation.
- Owns the 74-entry parameter register file and serves it to the forward pass through a registered read port.

Parameters:
- BATCH, 4, samples per update (power of two, 1..16).
- LOG2_BATCH, 2, log2(BATCH).
- FRAC_BITS, 8, fractional bits of every 16-bit fixed-point operand (weights, grads, lr).
- N_PARAM, 74, number of parameter words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (synchronous, active-high).
- grad_valid  in  1  gradient word present this cycle.
- grad_idx  in  7  parameter index of the gradient word.
- grad_data  in  16  signed gradient, Q(16-FRAC_BITS).FRAC_BITS.
- sample_done  in  1  single-cycle pulse: the current sample's gradients are complete.
- lr  in  16  unsigned learning rate, same Q format; sampled at APPLY entry.
- init_valid  in  1  direct parameter write.
- init_idx  in  7  parameter index for init write.
- init_data  in  16  signed value for init write.
- rd_idx  in  7  read index.
- rd_data  out  16  signed parameter at rd_idx, one-cycle latency.
- busy  out  1  high while in APPLY.
- update_done  out  1  single-cycle pulse after the last parameter is written.
- sample_cnt  out  LOG2_BATCH+1  samples accumulated in the current batch.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - On reset: all parameters = 0, all accumulators = 0, state = ACCUM, sample_cnt = 0, busy = 0, update_done = 0, rd_data = 0.
  - Reset asserted mid-APPLY aborts the sweep. Nothing is preserved; weights are reset to 0.
- Index map: idx = o*5+h for w3, 20+o for b3, 24+h*9+i for w2, 69+h for b2. Indices >= 74 are ignored on every port; a read of such an index returns 0.
- Accumulators: ACC_W = 16+LOG2_BATCH+1 bits, signed.
  - grad_valid in ACCUM: acc[idx] <= sat(acc[idx] + sext(grad_data)).
  - A repeated idx within one sample simply adds again.
- State ACCUM:
  - sample_done increments sample_cnt.
  - When sample_done arrives with sample_cnt == BATCH-1, go to APPLY next cycle, latch lr, set ptr = 0, and reset sample_cnt to 0.
  - A grad_valid in the same cycle as that sample_done is accumulated before the sweep.
- State APPLY (busy = 1), one index per cycle, ptr = 0..73:
  - prod = lr * acc[ptr], signed, width ACC_W+17.
  - step = prod >>> (FRAC_BITS+LOG2_BATCH), arithmetic shift (floor).
  - w[ptr] <= sat16(w[ptr] - step), clamped to [0x8000, 0x7FFF].
  - acc[ptr] <= 0.
  - After ptr = 73: update_done = 1 for one cycle, state returns to ACCUM.
  - Total sweep: exactly 74 cycles busy.
- Inputs ignored during APPLY: grad_valid, sample_done and init_valid are dropped. Upstream must hold off while busy.
- Init writes (ACCUM only): w[init_idx] <= init_data. Accumulators are untouched.
- Read port:
  - rd_data <= w[rd_idx] on every cycle, in any state, showing the stored value.
  - Reading the index written in the same cycle returns the old value (read-before-write).
- update_done and busy are registered outputs.

Decomposition:
- Shared package dqn_pkg:
  - Q-format constants (DATA_W = 16, FRAC_BITS).
  - Index-base constants: W3_BASE = 0, B3_BASE = 20, W2_BASE = 24, B2_BASE = 69, N_PARAM = 74.
  - Saturation function sat16.
  - State enum {ACCUM, APPLY}.
- One sub-module, dqn_sgd_step: a purely combinational datapath computing the new weight from (w, acc, lr).
- The parent holds the FSM, the counters and the storage.

Test Plan:
- Basic update:
  - Stimulus: init w[0] = 0x0100, lr = 0x0040; four samples, each grad_valid idx 0 data 0x0100 followed by sample_done.
  - Response: busy 74 cycles, update_done pulse, then rd_idx 0 returns 0x00C0.
- Sign and floor:
  - Stimulus: w[20] = 0, lr = 0x0100; grads for idx 20 of -1, 0, 0, 0 (0xFFFF) over the batch.
  - Response: step = floor(-1/4) = -1, so w[20] = 0x0001.
- Saturation:
  - Stimulus: w[73] = 0x7F00, lr = 0x7FFF; four grads of 0x8000 at idx 73.
  - Response: w[73] = 0x7FFF. Accumulator cleared: a following all-zero batch leaves w[73] unchanged.
- Busy drop:
  - Stimulus: during APPLY drive grad_valid idx 5 data 0x0100 and init_valid idx 5 data 0x1234.
  - Response: both are ignored. The next zero-gradient batch leaves w[5] at its pre-APPLY value.
- Boundary and read latency:
  - Stimulus: grad idx 74, init idx 100, rd_idx 127.
  - Response: no state change, rd_data = 0. Also, init_valid idx 3 data 0x0055 with rd_idx 3 in the same cycle returns the old value, and 0x0055 one cycle later.
- Reset mid-sweep:
  - Stimulus: assert rst at ptr = 30.
  - Response: next cycle busy = 0, sample_cnt = 0, rd_data of every index = 0, update_done never pulses.
